// File: rtl/led_mode_ctrl.sv
// Button-cycled LED mode controller: switch passthrough, blink, chase and binary count.
// Define LED_DEBOUNCE_EN to debounce the synchronized button before edge detection.
module led_mode_ctrl #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned TICK_DIV        = 1000000,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk_in,
  input  logic             rst_low_in,
  input  logic [WIDTH-1:0] sw_in,
  input  logic             btn_in,
  output logic [WIDTH-1:0] led_out,
  output logic [1:0]       mode_out,
  output logic             tick_out
);

  localparam int unsigned CntW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    ModePass  = 2'd0,
    ModeBlink = 2'd1,
    ModeChase = 2'd2,
    ModeCount = 2'd3
  } mode_e;

  if (WIDTH < 1 || TICK_DIV < 2 || DEBOUNCE_CYCLES < 1) begin : gen_param_check
    $error("led_mode_ctrl: parameter out of range");
  end

  logic             sync1_q, sync2_q, prev_q;
  logic             btn_lvl, advance;
  logic [CntW-1:0]  pre_q, pre_d;
  logic             strobe, tick_q;
  mode_e            mode_q, mode_d;
  logic             phase_q, phase_d;
  logic [WIDTH-1:0] chase_q, chase_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] led_q, led_d;

  always_ff @(posedge clk_in) begin
    if (!rst_low_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      prev_q  <= btn_lvl;
    end
  end

`ifdef LED_DEBOUNCE_EN
  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic           db_q;
  logic [DbW-1:0] db_cnt_q;

  // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk_in) begin
    if (!rst_low_in) begin
      db_q     <= 1'b0;
      db_cnt_q <= '0;
    end else if (sync2_q != db_q) begin
      if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
        db_q     <= sync2_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DbW'(1);
      end
    end else begin
      db_cnt_q <= '0;
    end
  end

  assign btn_lvl = db_q;
`else
  assign btn_lvl = sync2_q;
`endif

  assign advance = btn_lvl & ~prev_q;
  assign strobe  = (pre_q == CntW'(TICK_DIV - 1));
  assign pre_d   = strobe ? '0 : pre_q + CntW'(1);

  always_comb begin
    mode_d  = mode_q;
    phase_d = phase_q;
    chase_d = chase_q;
    count_d = count_q;
    led_d   = '0;

    // A mode change takes priority over a coincident strobe.
    if (advance) begin
      unique case (mode_q)
        ModePass: begin
          mode_d  = ModeBlink;
          phase_d = 1'b0;
        end
        ModeBlink: begin
          mode_d  = ModeChase;
          chase_d = WIDTH'(1);
        end
        ModeChase: begin
          mode_d  = ModeCount;
          count_d = '0;
        end
        ModeCount: begin
          mode_d = ModePass;
        end
      endcase
    end else if (strobe) begin
      case (mode_q)
        ModeBlink: phase_d = ~phase_q;
        ModeChase: chase_d = (chase_q << 1) | (chase_q >> (WIDTH - 1));
        ModeCount: count_d = count_q + WIDTH'(1);
        default:   ;
      endcase
    end

    unique case (mode_q)
      ModePass:  led_d = sw_in;
      ModeBlink: led_d = phase_q ? sw_in : '0;
      ModeChase: led_d = chase_q;
      ModeCount: led_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_low_in) begin
      pre_q   <= '0;
      tick_q  <= 1'b0;
      mode_q  <= ModePass;
      phase_q <= 1'b0;
      chase_q <= WIDTH'(1);
      count_q <= '0;
      led_q   <= '0;
    end else begin
      pre_q   <= pre_d;
      tick_q  <= strobe;
      mode_q  <= mode_d;
      phase_q <= phase_d;
      chase_q <= chase_d;
      count_q <= count_d;
      led_q   <= led_d;
    end
  end

  assign led_out  = led_q;
  assign mode_out = mode_q;
  assign tick_out = tick_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with WIDTH=8, TICK_DIV=4, DEBOUNCE_CYCLES=4.
module tb_led_mode_ctrl;

  localparam int W  = 8;
  localparam int TD = 4;
  localparam int DB = 4;
`ifdef LED_DEBOUNCE_EN
  localparam int LAT = 3 + DB;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_low = 1'b0;
  logic       btn = 1'b0;
  logic [7:0] sw = 8'h00;
  logic [7:0] led;
  logic [1:0] mode;
  logic       tick;

  led_mode_ctrl #(
    .WIDTH          (W),
    .TICK_DIV       (TD),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk_in    (clk),
    .rst_low_in(rst_low),
    .sw_in     (sw),
    .btn_in    (btn),
    .led_out   (led),
    .mode_out  (mode),
    .tick_out  (tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [7:0] sw;
    logic       btn;
    logic [7:0] led;
    logic [1:0] mode;
    logic       tick;
  } vec_t;

  vec_t vecs [10];

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;  // edges since reset release
  int cur_mode = 0;
  int cur_m    = 0;  // edge at which cur_mode was entered

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // LED value after edge k, for a mode entered at edge m: n strobes landed on edges m+1..k-1.
  function automatic logic [7:0] exp_led(input int md, input int m, input int k,
                                         input logic [7:0] s);
    int n;
    n = (k - 1) / TD - m / TD;
    case (md)
      0:       return s;
      1:       return (n % 2 == 1) ? s : 8'h00;
      2:       return 8'(1 << (n % 8));
      default: return 8'(n % 256);
    endcase
  endfunction

  task automatic drive(input logic r, input logic [7:0] s, input logic b);
    rst_low = r;
    sw      = s;
    btn     = b;
    @(posedge clk);
    #1;
    if (!r) cyc = 0;
    else    cyc++;
  endtask

  task automatic step(input logic r, input logic [7:0] s, input logic b, input bit adv);
    logic [7:0] want_led;
    want_led = r ? exp_led(cur_mode, cur_m, cyc + 1, s) : 8'h00;
    drive(r, s, b);
    if (!r) begin
      cur_mode = 0;
      cur_m    = 0;
    end else if (adv) begin
      cur_mode = (cur_mode + 1) % 4;
      cur_m    = cyc;
    end
    chk("led", int'(led), int'(want_led));
    chk("mode", int'(mode), cur_mode);
    chk("tick", int'(tick), (r && cyc % TD == 0 && cyc != 0) ? 1 : 0);
  endtask

  task automatic run(input int n, input bit vary, input logic [7:0] s);
    for (int i = 0; i < n; i++) step(1'b1, vary ? 8'(cyc * 29 + 7) : s, 1'b0, 1'b0);
  endtask

  // Hold the button 10 cycles; collide selects whether the mode change lands on a strobe edge.
  task automatic press(input bit collide, input logic [7:0] s);
    while ((((cyc + LAT) % TD) == 0) != collide) step(1'b1, s, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, s, 1'b1, i == LAT - 1);
    for (int i = 0; i < 10; i++) step(1'b1, s, 1'b0, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'hA5, 1'b1, 8'h00, 2'd0, 1'b0};
    vecs[1] = '{1'b0, 8'hA5, 1'b1, 8'h00, 2'd0, 1'b0};
    vecs[2] = '{1'b1, 8'hA5, 1'b0, 8'hA5, 2'd0, 1'b0};
    vecs[3] = '{1'b1, 8'h5A, 1'b0, 8'h5A, 2'd0, 1'b0};
    vecs[4] = '{1'b1, 8'h5A, 1'b0, 8'h5A, 2'd0, 1'b0};
    vecs[5] = '{1'b1, 8'h5A, 1'b0, 8'h5A, 2'd0, 1'b1};
    vecs[6] = '{1'b1, 8'hC3, 1'b0, 8'hC3, 2'd0, 1'b0};
    vecs[7] = '{1'b1, 8'hC3, 1'b0, 8'hC3, 2'd0, 1'b0};
    vecs[8] = '{1'b1, 8'hC3, 1'b0, 8'hC3, 2'd0, 1'b0};
    vecs[9] = '{1'b1, 8'hC3, 1'b0, 8'hC3, 2'd0, 1'b1};

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].rst, vecs[i].sw, vecs[i].btn);
      chk("tbl_led", int'(led), int'(vecs[i].led));
      chk("tbl_mode", int'(mode), int'(vecs[i].mode));
      chk("tbl_tick", int'(tick), int'(vecs[i].tick));
    end

    run(4, 1'b1, 8'h00);
    press(1'b0, 8'h3C);           // PASS -> BLINK
    run(20, 1'b0, 8'h3C);
    run(8, 1'b1, 8'h00);          // switch changes track while phase is high
    press(1'b1, 8'h00);           // BLINK -> CHASE on a strobe edge
    run(40, 1'b0, 8'h00);
    step(1'b0, 8'h77, 1'b0, 1'b0); // reset mid-chase
    run(3, 1'b1, 8'h00);
    press(1'b0, 8'h11);           // -> BLINK
    press(1'b0, 8'h22);           // -> CHASE
    press(1'b1, 8'h33);           // -> COUNT on a strobe edge
    run(1040, 1'b0, 8'h33);       // full 8-bit wrap
    press(1'b0, 8'h99);           // -> PASS
    run(5, 1'b1, 8'h00);

`ifdef LED_DEBOUNCE_EN
    for (int i = 0; i < 3; i++) step(1'b1, 8'h44, 1'b1, 1'b0);
    run(12, 1'b0, 8'h44);
    press(1'b0, 8'h55);           // clean press still advances
    run(6, 1'b0, 8'h55);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
